// File: rtl/bridge_top_if.sv
// AHB-Lite slave / APB master signal bundle seen by bridge_top.
// slave: the bridge's view; master: the view of the AHB master and APB peripherals around it.
interface bridge_top_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  Hwrite;
  logic                  Hreadyin;
  logic [1:0]            Htrans;
  logic [2:0]            Hsize;
  logic [2:0]            Hburst;
  logic [DATA_WIDTH-1:0] Hwdata;
  logic [ADDR_WIDTH-1:0] Haddr;
  logic [DATA_WIDTH-1:0] Hrdata;
  logic [1:0]            Hresp;
  logic                  Hreadyout;
  logic [DATA_WIDTH-1:0] Prdata;
  logic [DATA_WIDTH-1:0] Pwdata;
  logic [ADDR_WIDTH-1:0] Paddr;
  logic [2:0]            Pselx;
  logic                  Pwrite;
  logic                  Penable;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Hsize, Hburst, Hwdata, Haddr, Prdata,
    output Hrdata, Hresp, Hreadyout, Pwdata, Paddr, Pselx, Pwrite, Penable
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Hsize, Hburst, Hwdata, Haddr, Prdata,
    input  Hrdata, Hresp, Hreadyout, Pwdata, Paddr, Pselx, Pwrite, Penable
  );
endinterface

// File: rtl/bridge_top.sv
// Single-clock AHB-Lite slave to APB master bridge for three peripherals.
// Optional BRIDGE_COV_EN adds transfer counters (cov_inst) and display_coverage().
module bridge_top #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic          Hclk,
  input logic          Hresetn,
  bridge_top_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWwait, StSetup, StEnable} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [2:0]            sel_q, sel_d;

  logic [5:0] addr_hi;
  logic       in_range;
  logic       valid;
  logic [2:0] decode;

  // Bridge window is 0x8000_0000..0x8BFF_FFFF; bits [27:26] pick the peripheral.
  always_comb begin
    addr_hi  = bus.Haddr[ADDR_WIDTH-1 -: 6];
    in_range = (addr_hi[5:2] == 4'h8) && (addr_hi[1:0] != 2'b11);
    valid    = bus.Hreadyin & bus.Htrans[1] & in_range;
    unique case (addr_hi[1:0])
      2'b00:   decode = 3'b001;
      2'b01:   decode = 3'b010;
      2'b10:   decode = 3'b100;
      default: decode = 3'b000;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    sel_d    = sel_q;
    unique case (state_q)
      // ENABLE doubles as an address-phase slot so back-to-back beats need no bubble.
      StIdle, StEnable: begin
        if (valid) begin
          paddr_d  = bus.Haddr;
          pwrite_d = bus.Hwrite;
          sel_d    = decode;
          state_d  = bus.Hwrite ? StWwait : StSetup;
        end else begin
          state_d  = StIdle;
        end
      end
      StWwait: begin
        pwdata_d = bus.Hwdata;
        state_d  = StSetup;
      end
      StSetup: state_d = StEnable;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    bus.Hrdata    = '0;
    bus.Pselx     = 3'b000;
    bus.Penable   = 1'b0;
    bus.Paddr     = paddr_q;
    bus.Pwrite    = pwrite_q;
    bus.Pwdata    = pwdata_q;
    unique case (state_q)
      StIdle:  bus.Hreadyout = 1'b1;
      StWwait: bus.Hreadyout = 1'b0;
      StSetup: begin
        bus.Hreadyout = 1'b0;
        bus.Pselx     = sel_q;
      end
      StEnable: begin
        bus.Pselx   = sel_q;
        bus.Penable = 1'b1;
        if (!pwrite_q) bus.Hrdata = bus.Prdata;
      end
      default: bus.Hreadyout = 1'b1;
    endcase
  end

  // Size and burst type do not affect a 32-bit single-beat conversion.
  logic unused_ok;
  assign unused_ok = ^{bus.Hsize, bus.Hburst, bus.Htrans[0]};

`ifdef BRIDGE_COV_EN
  logic accept;
  assign accept = valid & ((state_q == StIdle) | (state_q == StEnable));

  if (1) begin : cov_inst
    logic [31:0] reads_q, reads_d, writes_q, writes_d, b2b_q, b2b_d;
    logic [31:0] sel_cnt_q [3];
    logic [31:0] sel_cnt_d [3];

    always_comb begin
      reads_d  = reads_q + {31'd0, accept & ~bus.Hwrite};
      writes_d = writes_q + {31'd0, accept & bus.Hwrite};
      b2b_d    = b2b_q + {31'd0, accept & (state_q == StEnable)};
      for (int i = 0; i < 3; i++) sel_cnt_d[i] = sel_cnt_q[i] + {31'd0, accept & decode[i]};
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
        reads_q  <= '0;
        writes_q <= '0;
        b2b_q    <= '0;
        for (int i = 0; i < 3; i++) sel_cnt_q[i] <= '0;
      end else begin
        reads_q  <= reads_d;
        writes_q <= writes_d;
        b2b_q    <= b2b_d;
        for (int i = 0; i < 3; i++) sel_cnt_q[i] <= sel_cnt_d[i];
      end
    end
  end

  task automatic display_coverage();
    $display("bridge cov: reads=%0d writes=%0d sel0=%0d sel1=%0d sel2=%0d b2b=%0d",
             cov_inst.reads_q, cov_inst.writes_q, cov_inst.sel_cnt_q[0],
             cov_inst.sel_cnt_q[1], cov_inst.sel_cnt_q[2], cov_inst.b2b_q);
  endtask
`endif

endmodule

// File: tb/tb_bridge_top.sv
// Directed bench for bridge_top: vector table of single transfers plus
// hand sequences for back-to-back transfers and reset in the middle of SETUP.
module tb_bridge_top;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bridge_top_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  bridge_top u_dut (
    .Hclk    (clk),
    .Hresetn (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  trans;
    logic        rdy;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic [2:0]  exp_sel;
    int          exp_low;
    logic [31:0] exp_rdata;
  } vec_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Expected held values of the APB address/direction/data registers.
  logic [31:0] exp_paddr  = 32'h0;
  logic        exp_pwrite = 1'b0;
  logic [31:0] exp_pwdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Caller is 1 time unit after a rising edge; returns in the same position.
  task automatic do_xfer(input vec_t v, input string tag);
    int          low = 0;
    int          pen = 0;
    int          cyc = 0;
    int          bad = 0;
    logic [2:0]  sel_seen = 3'b000;
    logic [31:0] rdata = 32'h0;
    logic        done = 1'b0;
    bus.Hwrite   = v.wr;
    bus.Htrans   = v.trans;
    bus.Hreadyin = v.rdy;
    bus.Haddr    = v.addr;
    bus.Prdata   = v.prdata;
    @(posedge clk);
    #1;
    bus.Htrans   = 2'b00;
    bus.Hreadyin = 1'b1;
    bus.Hwdata   = v.wdata;
    while (!done && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus.Hresp != 2'b00) bad++;
      if (!(bus.Penable && !bus.Pwrite) && bus.Hrdata != 32'h0) bad++;
      if (!bus.Hreadyout) low++;
      if (bus.Penable) begin
        pen++;
        rdata = bus.Hrdata;
      end
      sel_seen |= bus.Pselx;
      if (bus.Hreadyout && !bus.Penable && bus.Pselx == 3'b000) done = 1'b1;
    end
    if (v.exp_sel != 3'b000) begin
      exp_paddr  = v.addr;
      exp_pwrite = v.wr;
      if (v.wr) exp_pwdata = v.wdata;
    end
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " pselx"}, {29'd0, sel_seen}, {29'd0, v.exp_sel});
    check({tag, " penable cycles"}, pen, (v.exp_sel != 3'b000) ? 1 : 0);
    check({tag, " hreadyout low cycles"}, low, v.exp_low);
    check({tag, " hrdata"}, rdata, v.exp_rdata);
    check({tag, " hresp/hrdata outside read enable"}, bad, 0);
    check({tag, " paddr"}, bus.Paddr, exp_paddr);
    check({tag, " pwrite"}, {31'd0, bus.Pwrite}, {31'd0, exp_pwrite});
    check({tag, " pwdata"}, bus.Pwdata, exp_pwdata);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];
  vec_t post;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 2'b10, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_0000, 3'b001, 2, 32'h0};
    vecs[1] = '{1'b0, 2'b10, 1'b1, 32'h8400_0004, 32'h0, 32'h1234_5678, 3'b010, 1, 32'h1234_5678};
    vecs[2] = '{1'b0, 2'b10, 1'b1, 32'h9000_0000, 32'h0, 32'h1111_1111, 3'b000, 0, 32'h0};
    vecs[3] = '{1'b1, 2'b00, 1'b1, 32'h8000_0000, 32'h2222_2222, 32'h0, 3'b000, 0, 32'h0};
    vecs[4] = '{1'b1, 2'b01, 1'b1, 32'h8400_0000, 32'h3333_3333, 32'h0, 3'b000, 0, 32'h0};
    vecs[5] = '{1'b1, 2'b10, 1'b0, 32'h8800_0000, 32'h4444_4444, 32'h0, 3'b000, 0, 32'h0};
    vecs[6] = '{1'b0, 2'b10, 1'b1, 32'h8C00_0000, 32'h0, 32'h5555_5555, 3'b000, 0, 32'h0};
    vecs[7] = '{1'b1, 2'b11, 1'b1, 32'h8BFF_FFFC, 32'hA5A5_0001, 32'h7777_0000, 3'b100, 2, 32'h0};
    vecs[8] = '{1'b0, 2'b11, 1'b1, 32'h87FF_FFFC, 32'h0, 32'h0F0F_F0F0, 3'b010, 1, 32'h0F0F_F0F0};
    vecs[9] = '{1'b0, 2'b10, 1'b1, 32'h7FFF_FFFC, 32'h0, 32'h6666_6666, 3'b000, 0, 32'h0};
    post    = '{1'b1, 2'b10, 1'b1, 32'h8400_0020, 32'h5555_AAAA, 32'h9999_0000, 3'b010, 2, 32'h0};

    rst_n        = 1'b0;
    bus.Hwrite   = 1'b0;
    bus.Hreadyin = 1'b1;
    bus.Htrans   = 2'b00;
    bus.Hsize    = 3'b010;
    bus.Hburst   = 3'b000;
    bus.Hwdata   = 32'h0;
    bus.Haddr    = 32'h0;
    bus.Prdata   = 32'hABCD_EF01;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset hreadyout", {31'd0, bus.Hreadyout}, 32'd1);
    check("reset hresp", {30'd0, bus.Hresp}, 32'd0);
    check("reset hrdata", bus.Hrdata, 32'h0);
    check("reset pselx", {29'd0, bus.Pselx}, 32'd0);
    check("reset penable", {31'd0, bus.Penable}, 32'd0);
    check("reset pwrite", {31'd0, bus.Pwrite}, 32'd0);
    check("reset paddr", bus.Paddr, 32'h0);
    check("reset pwdata", bus.Pwdata, 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("hreadyout after release", {31'd0, bus.Hreadyout}, 32'd1);

    for (int i = 0; i < 10; i++) do_xfer(vecs[i], $sformatf("v%0d", i));

    // Back-to-back: read 0x8800_0000 then write 0x8000_0000 issued in its ENABLE cycle.
    bus.Hwrite = 1'b0; bus.Htrans = 2'b10; bus.Haddr = 32'h8800_0000; bus.Prdata = 32'hCAFE_0123;
    @(posedge clk);
    #1 bus.Htrans = 2'b00;
    @(negedge clk);
    check("b2b rd setup pselx", {29'd0, bus.Pselx}, 32'd4);
    check("b2b rd setup penable", {31'd0, bus.Penable}, 32'd0);
    check("b2b rd setup hreadyout", {31'd0, bus.Hreadyout}, 32'd0);
    @(posedge clk);
    #1 begin bus.Hwrite = 1'b1; bus.Htrans = 2'b10; bus.Haddr = 32'h8000_0000; end
    @(negedge clk);
    check("b2b rd enable pselx", {29'd0, bus.Pselx}, 32'd4);
    check("b2b rd enable penable", {31'd0, bus.Penable}, 32'd1);
    check("b2b rd enable hrdata", bus.Hrdata, 32'hCAFE_0123);
    @(posedge clk);
    #1 begin bus.Htrans = 2'b00; bus.Hwdata = 32'h0BAD_F00D; end
    @(negedge clk);
    check("b2b wr wwait hreadyout", {31'd0, bus.Hreadyout}, 32'd0);
    check("b2b wr wwait penable", {31'd0, bus.Penable}, 32'd0);
    @(negedge clk);
    check("b2b wr setup pselx", {29'd0, bus.Pselx}, 32'd1);
    check("b2b wr setup penable", {31'd0, bus.Penable}, 32'd0);
    check("b2b wr setup paddr", bus.Paddr, 32'h8000_0000);
    check("b2b wr setup pwrite", {31'd0, bus.Pwrite}, 32'd1);
    check("b2b wr setup pwdata", bus.Pwdata, 32'h0BAD_F00D);
    @(negedge clk);
    check("b2b wr enable pselx", {29'd0, bus.Pselx}, 32'd1);
    check("b2b wr enable penable", {31'd0, bus.Penable}, 32'd1);
    check("b2b wr enable hreadyout", {31'd0, bus.Hreadyout}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back reads: SETUP of the second follows the first ENABLE directly.
    bus.Hwrite = 1'b0; bus.Htrans = 2'b10; bus.Haddr = 32'h8400_0008; bus.Prdata = 32'h0000_00AA;
    @(posedge clk);
    #1 bus.Htrans = 2'b00;
    @(posedge clk);
    #1 begin bus.Htrans = 2'b10; bus.Haddr = 32'h8800_0004; end
    @(negedge clk);
    check("b2b rr first enable hrdata", bus.Hrdata, 32'h0000_00AA);
    @(posedge clk);
    #1 bus.Htrans = 2'b00;
    @(negedge clk);
    check("b2b rr second setup pselx", {29'd0, bus.Pselx}, 32'd4);
    check("b2b rr second setup penable", {31'd0, bus.Penable}, 32'd0);
    check("b2b rr second setup paddr", bus.Paddr, 32'h8800_0004);
    @(negedge clk);
    check("b2b rr second enable penable", {31'd0, bus.Penable}, 32'd1);
    @(posedge clk);
    #1;

    // Reset asserted during SETUP clears the APB side without waiting for a clock edge.
    bus.Hwrite = 1'b0; bus.Htrans = 2'b10; bus.Haddr = 32'h8400_0004;
    @(posedge clk);
    #1 bus.Htrans = 2'b00;
    @(negedge clk);
    check("mid-reset setup pselx", {29'd0, bus.Pselx}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("mid-reset pselx", {29'd0, bus.Pselx}, 32'd0);
    check("mid-reset penable", {31'd0, bus.Penable}, 32'd0);
    check("mid-reset hreadyout", {31'd0, bus.Hreadyout}, 32'd1);
    check("mid-reset paddr", bus.Paddr, 32'h0);
    #1 rst_n = 1'b1;
    exp_paddr  = 32'h0;
    exp_pwrite = 1'b0;
    exp_pwdata = 32'h0;
    @(posedge clk);
    #1;
    do_xfer(post, "post-reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
